pc_jump_ctl: RTL and testbench

//  Control-side driver for the 8-bit PC: decodes flow-control ops, drives PCincr/pc_data.

---
 rtl/pc_jump_ctl.sv | 190 +++++++++++++++++++
 tb/tb_pc_jump_ctl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_jump_ctl.sv
// pc_jump_ctl: flow-control driver for the program counter.
// Decodes JMP/JZ/JNZ/JC/CALL/RET/HALT and tells the PC, on the same
// clock edge, whether to increment or to load pc_data. CALL/RET use a
// LIFO return-address stack of DEPTH entries. Overflow and underflow
// are recorded in sticky flags that clear only on reset.
// Optional feature macro: JUMPCTL_FLUSH_EN. When it is defined, every
// taken transfer spends one cycle in FLUSH so the instruction fetched
// behind the branch is discarded. When it is not defined, flush is tied
// low and a taken transfer goes straight back to RUN.
module pc_jump_ctl #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         op_valid,
  input  logic [2:0]                   op,
  input  logic [DW-1:0]                target,
  input  logic                         zflag,
  input  logic                         cflag,
  input  logic [DW-1:0]                pc_value,
  output logic                         PCincr,
  output logic [DW-1:0]                pc_data,
  output logic                         flush,
  output logic                         halted,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         stk_ovf,
  output logic                         stk_unf
);

  localparam int DPW = $clog2(DEPTH + 1);
  localparam logic [DPW-1:0] FULL = DPW'(DEPTH);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_JNZ  = 3'd3;
  localparam logic [2:0] OP_JC   = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
`ifdef JUMPCTL_FLUSH_EN
    ST_FLUSH  = 2'd1,
`endif
    ST_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DPW-1:0]    r_depth;
  logic              r_ovf;
  logic              r_unf;
  // Entry 0 is always the top of stack; pushes shift older entries down.
  logic [DW-1:0]     r_stk [DEPTH];

  logic              w_full;
  logic              w_empty;
  logic              w_taken;
  logic              w_push;
  logic              w_pop;
  logic              w_set_ovf;
  logic              w_set_unf;
  logic [DW-1:0]     w_ret_addr;

  assign w_full     = (r_depth == FULL);
  assign w_empty    = (r_depth == '0);
  // Return address wraps naturally at 2^DW (FF -> 00).
  assign w_ret_addr = pc_value + DW'(1);

  // Next-state and same-cycle PC control decode.
  always_comb begin
    w_next    = r_state;
    PCincr    = 1'b1;
    pc_data   = '0;
    flush     = 1'b0;
    w_taken   = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (op_valid) begin
          case (op)
            OP_NOP:  w_taken = 1'b0;
            OP_JMP:  w_taken = 1'b1;
            OP_JZ:   w_taken = zflag;
            OP_JNZ:  w_taken = ~zflag;
            OP_JC:   w_taken = cflag;
            OP_CALL: begin
              if (!w_full) begin
                w_push  = 1'b1;
                w_taken = 1'b1;
              end else begin
                w_set_ovf = 1'b1;
              end
            end
            OP_RET: begin
              if (!w_empty) begin
                w_pop   = 1'b1;
                w_taken = 1'b1;
              end else begin
                w_set_unf = 1'b1;
              end
            end
            OP_HALT: begin
              PCincr  = 1'b0;
              pc_data = pc_value;
              w_next  = ST_HALTED;
            end
            default: w_taken = 1'b0;
          endcase
          if (w_taken) begin
            PCincr  = 1'b0;
            pc_data = w_pop ? r_stk[0] : target;
`ifdef JUMPCTL_FLUSH_EN
            w_next  = ST_FLUSH;
`else
            w_next  = ST_RUN;
`endif
          end
        end
      end
`ifdef JUMPCTL_FLUSH_EN
      ST_FLUSH: begin
        // The instruction fetched behind the branch is dropped; op ignored.
        flush  = 1'b1;
        w_next = ST_RUN;
      end
`endif
      ST_HALTED: begin
        // PC reloads its own value so it stays frozen until reset.
        PCincr  = 1'b0;
        pc_data = pc_value;
      end
      default: w_next = ST_RUN;
    endcase
    if (reset) begin
      PCincr  = 1'b1;
      pc_data = '0;
      flush   = 1'b0;
    end
  end

  // Control state: FSM register, stack occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) begin
        r_depth <= r_depth + DPW'(1);
      end else if (w_pop) begin
        r_depth <= r_depth - DPW'(1);
      end
      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end
      if (w_set_unf) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Return-address storage: shift down on push, shift up on pop.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stk[0] <= w_ret_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_stk[i] <= r_stk[i-1];
      end
    end else if (w_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        r_stk[i] <= r_stk[i+1];
      end
    end
  end

  assign halted  = (r_state == ST_HALTED);
  assign depth   = r_depth;
  assign stk_ovf = r_ovf;
  assign stk_unf = r_unf;

endmodule

// File: tb/tb_pc_jump_ctl.sv
// Testbench for pc_jump_ctl: directed scenarios plus a randomized run
// scored against a queue-based behavioural model of the controller.
module tb_pc_jump_ctl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] target = 8'h00;
  logic       zflag = 1'b0;
  logic       cflag = 1'b0;
  logic [7:0] pc_value = 8'h00;
  logic       PCincr;
  logic [7:0] pc_data;
  logic       flush;
  logic       halted;
  logic [2:0] depth;
  logic       stk_ovf;
  logic       stk_unf;

  pc_jump_ctl #(.DEPTH(DEPTH), .DW(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .target(target),
    .zflag(zflag), .cflag(cflag), .pc_value(pc_value), .PCincr(PCincr),
    .pc_data(pc_data), .flush(flush), .halted(halted), .depth(depth),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [7:0] m_stk[$];
  bit         m_halt, m_fl, m_ovf, m_unf;
  // Expected outputs for the current cycle
  logic       e_incr, e_flush, e_halted, e_ovf, e_unf;
  logic [7:0] e_data;
  logic [2:0] e_depth;
  // Actions the model will take at the coming edge
  bit         a_taken, a_push, a_pop, a_set_ovf, a_set_unf, a_halt;
  logic [7:0] a_push_val;

  task model_reset();
    m_stk.delete();
    m_halt = 0; m_fl = 0; m_ovf = 0; m_unf = 0;
  endtask

  task model_eval();
    a_taken = 0; a_push = 0; a_pop = 0; a_set_ovf = 0; a_set_unf = 0; a_halt = 0;
    e_incr = 1'b1; e_data = 8'h00; e_flush = 1'b0;
    e_halted = m_halt; e_ovf = m_ovf; e_unf = m_unf;
    e_depth = 3'(m_stk.size());
    a_push_val = 8'((int'(pc_value) + 1) % 256);
    if (m_halt) begin
      e_incr = 1'b0;
      e_data = pc_value;
    end else if (m_fl) begin
      e_flush = 1'b1;
    end else if (op_valid) begin
      a_taken = (op == 3'd1) || (op == 3'd2 && zflag) ||
                (op == 3'd3 && !zflag) || (op == 3'd4 && cflag);
      if (op == 3'd5) begin
        if (m_stk.size() < DEPTH) begin a_push = 1; a_taken = 1; end
        else a_set_ovf = 1;
      end
      if (op == 3'd6) begin
        if (m_stk.size() > 0) begin a_pop = 1; a_taken = 1; end
        else a_set_unf = 1;
      end
      if (op == 3'd7) begin
        a_halt = 1;
        e_incr = 1'b0;
        e_data = pc_value;
      end
      if (a_taken) begin
        e_incr = 1'b0;
        e_data = a_pop ? m_stk[$] : target;
      end
    end
  endtask

  task model_commit();
    if (m_fl) begin
      m_fl = 0;
    end else begin
      if (a_push) m_stk.push_back(a_push_val);
      if (a_pop) void'(m_stk.pop_back());
      if (a_set_ovf) m_ovf = 1;
      if (a_set_unf) m_unf = 1;
      if (a_halt) m_halt = 1;
`ifdef JUMPCTL_FLUSH_EN
      if (a_taken) m_fl = 1;
`endif
    end
  endtask

  task apply(input logic v, input logic [2:0] o, input logic [7:0] t,
             input logic z, input logic c, input logic [7:0] p);
    @(negedge clk);
    op_valid = v; op = o; target = t; zflag = z; cflag = c; pc_value = p;
    #1;
    model_eval();
  endtask

  task commit();
    @(posedge clk);
    model_commit();
  endtask

  task do_reset();
    @(negedge clk);
    reset = 1'b1;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Idle cycle that lets a pending flush drain in the flush build.
  task settle();
`ifdef JUMPCTL_FLUSH_EN
    apply(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, pc_value);
    commit();
`endif
  endtask

  task test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'(i));
      n_vec++;
      if ({PCincr, flush, halted, stk_ovf, stk_unf} !== 5'b10000) begin
        n_err++;
        $display("FAIL reset_ctl got %b want 10000", {PCincr, flush, halted, stk_ovf, stk_unf});
      end
      n_vec++;
      if (depth !== 3'd0) begin n_err++; $display("FAIL reset_depth got %0d want 0", depth); end
      n_vec++;
      if (pc_data !== 8'h00) begin n_err++; $display("FAIL reset_pcdata got %h want 00", pc_data); end
      commit();
    end
  endtask

  task test_cond_jump();
    do_reset();
    apply(1'b1, 3'd2, 8'h40, 1'b0, 1'b0, 8'h05);
    n_vec++;
    if (PCincr !== 1'b1) begin n_err++; $display("FAIL jz_nt_incr got %b want 1", PCincr); end
    commit();
    apply(1'b1, 3'd2, 8'h40, 1'b1, 1'b0, 8'h06);
    n_vec++;
    if ({PCincr, pc_data} !== {1'b0, 8'h40}) begin
      n_err++; $display("FAIL jz_t got incr=%b data=%h want incr=0 data=40", PCincr, pc_data);
    end
    commit();
    apply(1'b1, 3'd1, 8'h99, 1'b0, 1'b0, 8'h40);
`ifdef JUMPCTL_FLUSH_EN
    n_vec++;
    if ({flush, PCincr} !== 2'b11) begin
      n_err++; $display("FAIL jz_flush got flush=%b incr=%b want flush=1 incr=1", flush, PCincr);
    end
`else
    n_vec++;
    if ({flush, PCincr, pc_data} !== {1'b0, 1'b0, 8'h99}) begin
      n_err++; $display("FAIL jmp_next got flush=%b incr=%b data=%h want 0 0 99", flush, PCincr, pc_data);
    end
`endif
    commit();
    settle();
    apply(1'b1, 3'd3, 8'h22, 1'b1, 1'b0, 8'h41);
    n_vec++;
    if (PCincr !== 1'b1) begin n_err++; $display("FAIL jnz_nt_incr got %b want 1", PCincr); end
    commit();
    apply(1'b1, 3'd4, 8'h23, 1'b0, 1'b1, 8'h42);
    n_vec++;
    if ({PCincr, pc_data} !== {1'b0, 8'h23}) begin
      n_err++; $display("FAIL jc_t got incr=%b data=%h want incr=0 data=23", PCincr, pc_data);
    end
    commit();
    settle();
  endtask

  task test_call_ret();
    do_reset();
    apply(1'b1, 3'd5, 8'h80, 1'b0, 1'b0, 8'h10);
    n_vec++;
    if ({PCincr, pc_data} !== {1'b0, 8'h80}) begin
      n_err++; $display("FAIL call_t got incr=%b data=%h want incr=0 data=80", PCincr, pc_data);
    end
    commit();
    settle();
    apply(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'h85);
    n_vec++;
    if (depth !== 3'd1) begin n_err++; $display("FAIL call_depth got %0d want 1", depth); end
    n_vec++;
    if ({PCincr, pc_data} !== {1'b0, 8'h11}) begin
      n_err++; $display("FAIL ret_t got incr=%b data=%h want incr=0 data=11", PCincr, pc_data);
    end
    commit();
    settle();
    apply(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h11);
    n_vec++;
    if (depth !== 3'd0) begin n_err++; $display("FAIL ret_depth got %0d want 0", depth); end
    commit();
  endtask

  task test_wrap();
    do_reset();
    apply(1'b1, 3'd5, 8'h20, 1'b0, 1'b0, 8'hFF);
    commit();
    settle();
    apply(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'h20);
    n_vec++;
    if ({PCincr, pc_data} !== {1'b0, 8'h00}) begin
      n_err++; $display("FAIL ret_wrap got incr=%b data=%h want incr=0 data=00", PCincr, pc_data);
    end
    commit();
    settle();
  endtask

  task test_stack_limits();
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      apply(1'b1, 3'd5, 8'(8'h50 + i), 1'b0, 1'b0, 8'(8'h10 + i));
      n_vec++;
      if (PCincr !== ((i < DEPTH) ? 1'b0 : 1'b1)) begin
        n_err++; $display("FAIL call_%0d_incr got %b want %b", i, PCincr, (i < DEPTH) ? 1'b0 : 1'b1);
      end
      commit();
      settle();
    end
    apply(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h20);
    n_vec++;
    if ({depth, stk_ovf} !== {3'd4, 1'b1}) begin
      n_err++; $display("FAIL ovf got depth=%0d ovf=%b want depth=4 ovf=1", depth, stk_ovf);
    end
    commit();
    do_reset();
    apply(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    n_vec++;
    if ({depth, stk_ovf} !== {3'd0, 1'b0}) begin
      n_err++; $display("FAIL ovf_clear got depth=%0d ovf=%b want depth=0 ovf=0", depth, stk_ovf);
    end
    commit();
    apply(1'b1, 3'd6, 8'h77, 1'b0, 1'b0, 8'h01);
    n_vec++;
    if (PCincr !== 1'b1) begin n_err++; $display("FAIL unf_incr got %b want 1", PCincr); end
    commit();
    apply(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h02);
    n_vec++;
    if ({stk_unf, PCincr} !== 2'b11) begin
      n_err++; $display("FAIL unf got unf=%b incr=%b want unf=1 incr=1", stk_unf, PCincr);
    end
    commit();
  endtask

  task test_halt();
    do_reset();
    apply(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 8'h33);
    n_vec++;
    if ({PCincr, pc_data} !== {1'b0, 8'h33}) begin
      n_err++; $display("FAIL halt_op got incr=%b data=%h want incr=0 data=33", PCincr, pc_data);
    end
    commit();
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 3'd1, 8'($urandom), 1'b0, 1'b0, 8'h33);
      n_vec++;
      if ({halted, PCincr, pc_data} !== {1'b1, 1'b0, 8'h33}) begin
        n_err++;
        $display("FAIL halt_hold%0d got halted=%b incr=%b data=%h want 1 0 33", i, halted, PCincr, pc_data);
      end
      commit();
    end
    do_reset();
    apply(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h33);
    n_vec++;
    if ({halted, PCincr} !== 2'b01) begin
      n_err++; $display("FAIL halt_reset got halted=%b incr=%b want 0 1", halted, PCincr);
    end
    commit();
  endtask

  task test_random();
    int r;
    logic [2:0] o;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) do_reset();
      r = $urandom_range(0, 99);
      o = (r < 8) ? 3'd0 : (r < 22) ? 3'd1 : (r < 34) ? 3'd2 : (r < 46) ? 3'd3 :
          (r < 58) ? 3'd4 : (r < 78) ? 3'd5 : (r < 98) ? 3'd6 : 3'd7;
      apply(1'($urandom_range(0, 9) != 0), o, 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom));
      n_vec++;
      if ({PCincr, flush, halted} !== {e_incr, e_flush, e_halted}) begin
        n_err++;
        $display("FAIL rnd%0d_ctl got incr/flush/halt=%b%b%b want %b%b%b", n,
                 PCincr, flush, halted, e_incr, e_flush, e_halted);
      end
      n_vec++;
      if ({depth, stk_ovf, stk_unf} !== {e_depth, e_ovf, e_unf}) begin
        n_err++;
        $display("FAIL rnd%0d_stk got depth=%0d ovf=%b unf=%b want depth=%0d ovf=%b unf=%b", n,
                 depth, stk_ovf, stk_unf, e_depth, e_ovf, e_unf);
      end
      if (e_incr == 1'b0) begin
        n_vec++;
        if (pc_data !== e_data) begin
          n_err++; $display("FAIL rnd%0d_data got %h want %h", n, pc_data, e_data);
        end
      end
      commit();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cond_jump();
    test_call_ret();
    test_wrap();
    test_stack_limits();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
